fpu_issue_ctrl: RTL
===================

# fpu_issue_ctrl

Sequential issue/response controller on the requester side of the combinational FPU datapath. It accepts one FP operation at a time from the FP reservation station over a valid/ready handshake, holds the operands and opcode stable on the FPU inputs for an opcode-dependent multicycle window, then captures the FPU result. It presents the captured result with its ROB tag on the common data bus (CDB) under a second valid/ready handshake. It sits between the FP reservation station and the CDB arbiter, with a flush input from the ROB.

## Interface
- TAG_W, 6, ROB tag width
- LAT_ADD, 2, cycles for opcodes 0-1 (fadd/fsub)
- LAT_MUL, 3, cycles for opcode 2 (fmul)
- LAT_FMA, 4, cycles for opcodes 5-8
- LAT_DIV, 12, cycles for opcode 3 and opcode 4 (fdiv/fsqrt)
- LAT_CVT, 2, cycles for opcodes 19-22
- LAT_MISC, 1, cycles for opcodes 11-16 and 23-25

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  ROB mispredict/exception flush
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_op  in  5  FPU opcode, same encoding as the FPU mux (0-8, 11-16, 19-25)
- in_a, in_b, in_c  in  32  source operands
- in_tag  in  TAG_W  ROB tag
- in_rd_int  in  1  destination is the integer RF (feq/flt/fle/fcvt.w*/fmv.x.w)
- fpu_a, fpu_b, fpu_c  out  32  registered operands to FPU
- fpu_op  out  5  registered opcode to FPU
- fpu_result  in  32  combinational FPU result
- cdb_valid  out  1  result valid
- cdb_ready  in  1  CDB arbiter grant
- cdb_tag  out  TAG_W  tag of the result
- cdb_data  out  32  result
- cdb_int  out  1  registered in_rd_int
- cdb_illegal  out  1  opcode was unsupported

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - EXEC: operands held, down-counter running.
  - RESP: cdb_valid=1, waiting for cdb_ready.
- Accept on the edge where in_valid && in_ready && !flush:
  - Load fpu_a/b/c, fpu_op, the tag, and rd_int.
  - Load cnt = LAT(op)-1.
  - Go to EXEC.
- EXEC: when cnt==0, capture fpu_result into cdb_data and go to RESP; otherwise decrement cnt.
- Unsupported opcodes (9, 10, 17, 18, 26-31):
  - Latency is 1.
  - cdb_data = 0, cdb_illegal = 1.
  - fpu_op is still driven; its output is ignored.
- RESP exits on cdb_valid && cdb_ready.
  - in_ready = 1 in RESP when cdb_ready=1, so back-to-back issue is allowed.
  - A request accepted in that cycle goes directly to EXEC.
  - Otherwise the FSM returns to IDLE.
- flush has priority over everything:
  - Next state is IDLE; any pending result is dropped.
  - cdb_valid=0 next cycle; in_ready=0 during the flush cycle.
  - No request is accepted in the flush cycle.
- In RESP, cdb_data, cdb_tag, cdb_int and cdb_illegal stay stable until the handshake completes.
- cnt width: $clog2(max LAT)+1 bits. cnt never underflows.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0 during rst, 1 on the first cycle after.
  - cdb_valid=0; cdb_data, cdb_tag, cdb_int, cdb_illegal = 0.
  - fpu_a/b/c = 0; fpu_op = 0; cnt = 0.
- Latency: accepted on edge T, cdb_valid rises after edge T+LAT(op).
  - Examples: fadd is visible in cycle T+2; fdiv in cycle T+12.
- The FPU path is a multicycle path of LAT(op) cycles. fpu_* inputs change only on accept edges.
- Throughput: one op per LAT+1 cycles with cdb_ready held high and back-to-back issue.
- rst mid-EXEC or mid-RESP: the op is discarded. This is identical to flush, except in_ready=0 while rst is high.

## Structure
- fpu_pkg holds:
  - Opcode localparams (FOP_ADD=0 … FOP_FMAX=25).
  - Latency defaults.
  - FSM state typedef (IDLE/EXEC/RESP).
- Sub-module fpu_lat_lut: combinational in_op → {latency, illegal}, parameterised by the LAT_* values.
- The FPU instance sits beside this block at the next level up, not inside it.

## Test plan
- Reset, then fadd with a=0x3F800000, b=0x40000000 (1.0 + 2.0), cdb_ready=1 → cdb_valid at T+2, cdb_data=0x40400000, correct tag, cdb_int=0.
- fdiv with a=0x40C00000, b=0x40000000 (6.0 / 2.0), cdb_ready=0 for 5 cycles after T+12 → cdb_valid held with data 0x40400000 stable; in_ready=0 throughout; completes on the first cdb_ready.
- Two back-to-back flt ops (op=15, rd_int=1) with cdb_ready=1 → second accepted in the first op's RESP cycle; results 1 and 0 at T+1 and T+3.
- op=9 → cdb_valid at T+1, cdb_illegal=1, cdb_data=0.
- flush asserted at T+3 of an fmadd, with in_valid also high in that cycle → no cdb_valid ever for either op; in_ready=1 at T+4.
- rst asserted while in RESP → cdb_valid=0 and all outputs at their reset values after the edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared opcode encodings, default latencies and FSM state type for the
// FPU issue/response controller.
package fpu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] FOP_ADD      = 5'd0;
    localparam logic [OP_W-1:0] FOP_SUB      = 5'd1;
    localparam logic [OP_W-1:0] FOP_MUL      = 5'd2;
    localparam logic [OP_W-1:0] FOP_DIV      = 5'd3;
    localparam logic [OP_W-1:0] FOP_SQRT     = 5'd4;
    localparam logic [OP_W-1:0] FOP_FMADD    = 5'd5;
    localparam logic [OP_W-1:0] FOP_FMSUB    = 5'd6;
    localparam logic [OP_W-1:0] FOP_FNMSUB   = 5'd7;
    localparam logic [OP_W-1:0] FOP_FNMADD   = 5'd8;
    localparam logic [OP_W-1:0] FOP_FSGNJ    = 5'd11;
    localparam logic [OP_W-1:0] FOP_FSGNJN   = 5'd12;
    localparam logic [OP_W-1:0] FOP_FSGNJX   = 5'd13;
    localparam logic [OP_W-1:0] FOP_FEQ      = 5'd14;
    localparam logic [OP_W-1:0] FOP_FLT      = 5'd15;
    localparam logic [OP_W-1:0] FOP_FLE      = 5'd16;
    localparam logic [OP_W-1:0] FOP_FCVT_WS  = 5'd19;
    localparam logic [OP_W-1:0] FOP_FCVT_WUS = 5'd20;
    localparam logic [OP_W-1:0] FOP_FCVT_SW  = 5'd21;
    localparam logic [OP_W-1:0] FOP_FCVT_SWU = 5'd22;
    localparam logic [OP_W-1:0] FOP_FMV_XW   = 5'd23;
    localparam logic [OP_W-1:0] FOP_FMIN     = 5'd24;
    localparam logic [OP_W-1:0] FOP_FMAX     = 5'd25;

    localparam int unsigned LAT_ADD_DEF  = 2;
    localparam int unsigned LAT_MUL_DEF  = 3;
    localparam int unsigned LAT_FMA_DEF  = 4;
    localparam int unsigned LAT_DIV_DEF  = 12;
    localparam int unsigned LAT_CVT_DEF  = 2;
    localparam int unsigned LAT_MISC_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Largest latency class; illegal opcodes always take one cycle.
    function automatic int unsigned max_lat(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e, input int unsigned f);
        int unsigned m;
        m = 1;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        return m;
    endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Opcode to multicycle-window lookup; unsupported encodings flag illegal
// and take a single cycle.
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_FMA  = LAT_FMA_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_CVT  = LAT_CVT_DEF,
    parameter int unsigned LAT_MISC = LAT_MISC_DEF,
    parameter int unsigned LAT_W    = 5
) (
    input  logic [OP_W-1:0]  op,
    output logic [LAT_W-1:0] lat_c,
    output logic             illegal_c
);

    always_comb begin
        lat_c     = LAT_W'(1);
        illegal_c = 1'b0;
        case (op)
            FOP_ADD, FOP_SUB:                       lat_c = LAT_W'(LAT_ADD);
            FOP_MUL:                                lat_c = LAT_W'(LAT_MUL);
            FOP_DIV, FOP_SQRT:                      lat_c = LAT_W'(LAT_DIV);
            FOP_FMADD, FOP_FMSUB,
            FOP_FNMSUB, FOP_FNMADD:                 lat_c = LAT_W'(LAT_FMA);
            FOP_FCVT_WS, FOP_FCVT_WUS,
            FOP_FCVT_SW, FOP_FCVT_SWU:              lat_c = LAT_W'(LAT_CVT);
            FOP_FSGNJ, FOP_FSGNJN, FOP_FSGNJX,
            FOP_FEQ, FOP_FLT, FOP_FLE,
            FOP_FMV_XW, FOP_FMIN, FOP_FMAX:         lat_c = LAT_W'(LAT_MISC);
            default: begin
                lat_c     = LAT_W'(1);
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Requester-side issue/response controller: holds operands on the
// combinational FPU for the opcode's window, then offers the result on the CDB.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
    parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
    parameter int unsigned LAT_FMA  = LAT_FMA_DEF,
    parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
    parameter int unsigned LAT_CVT  = LAT_CVT_DEF,
    parameter int unsigned LAT_MISC = LAT_MISC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_c,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_rd_int,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [31:0]      fpu_c,
    output logic [4:0]       fpu_op,
    input  logic [31:0]      fpu_result,
    output logic             cdb_valid,
    input  logic             cdb_ready,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic             cdb_int,
    output logic             cdb_illegal
);

    localparam int unsigned LAT_MAX = max_lat(LAT_ADD, LAT_MUL, LAT_FMA, LAT_DIV, LAT_CVT, LAT_MISC);
    localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

    issue_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_c;
    logic [CNT_W-1:0] cnt_init_c;
    logic             illegal_c;
    logic             accept_c;

    fpu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_FMA  (LAT_FMA),
        .LAT_DIV  (LAT_DIV),
        .LAT_CVT  (LAT_CVT),
        .LAT_MISC (LAT_MISC),
        .LAT_W    (CNT_W)
    ) u_lat_lut (
        .op        (in_op),
        .lat_c     (lat_c),
        .illegal_c (illegal_c)
    );

    // A zero latency parameter would otherwise wrap the down-counter.
    assign cnt_init_c = (lat_c == '0) ? '0 : lat_c - CNT_W'(1);

    // Ready in IDLE, or in RESP when the current result leaves this cycle.
    assign in_ready = !rst && !flush &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && cdb_ready));
    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_c       <= '0;
            fpu_op      <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_int     <= 1'b0;
            cdb_illegal <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cdb_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_EXEC: begin
                    if (cnt == '0) begin
                        cdb_data  <= cdb_illegal ? 32'd0 : fpu_result;
                        cdb_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (cdb_ready) begin
                        cdb_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Accept overrides the RESP exit so back-to-back issue goes straight to EXEC.
            if (accept_c) begin
                fpu_a       <= in_a;
                fpu_b       <= in_b;
                fpu_c       <= in_c;
                fpu_op      <= in_op;
                cdb_tag     <= in_tag;
                cdb_int     <= in_rd_int;
                cdb_illegal <= illegal_c;
                cnt         <= cnt_init_c;
                cdb_valid   <= 1'b0;
                state       <= ST_EXEC;
            end
        end
    end

endmodule
